// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexes six 7-segment patterns onto one shared
// segment bus with one-hot digit selects. All six digits are snapshotted once
// per frame, each digit slot begins with a blanking interval, and selected
// digits can be blinked for time-set feedback.
`timescale 1ns/1ps
module display_scan_mux #(
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYCLES   = 500,
  parameter int BLINK_HALF     = 12500000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] s_Lsd,
  input  logic [6:0] s_Msd,
  input  logic [6:0] m_Lsd,
  input  logic [6:0] m_Msd,
  input  logic [6:0] h_Lsd,
  input  logic [6:0] h_Msd,
  input  logic       blink_en,
  input  logic [5:0] blink_mask,
  output logic [6:0] seg_out,
  output logic [5:0] dig_sel,
  output logic       frame_tick
);

  localparam int DIG_PERIOD = CLK_HZ / SCAN_HZ;
  localparam int SLOT_W     = (DIG_PERIOD > 2) ? $clog2(DIG_PERIOD) : 1;
  localparam int BLINK_W    = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

  localparam logic [6:0]         SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0]         DIG_NONE   = DIG_ACTIVE_LOW ? 6'h3F : 6'h00;
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIG_PERIOD - 1);
  localparam logic [SLOT_W-1:0]  SLOT_DRIVE = SLOT_W'(BLANK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [2:0]          idx_q, idx_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [6:0]          shadow_q [6];
  logic [6:0]          in_pat [6];
  logic                snap;
  logic [6:0]          seg_out_q, seg_out_d;
  logic [5:0]          dig_sel_q, dig_sel_d;
  logic                frame_tick_q, frame_tick_d;
  logic [5:0]          one_hot;

  // Gather the six live digit patterns into an index-addressable array.
  always_comb begin
    in_pat[0] = s_Lsd;
    in_pat[1] = s_Msd;
    in_pat[2] = m_Lsd;
    in_pat[3] = m_Msd;
    in_pat[4] = h_Lsd;
    in_pat[5] = h_Msd;
  end

  // Scan FSM next state: slot counter, digit index and frame snapshot strobe.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    snap    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      slot_d  = '0;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          slot_d  = '0;
          idx_d   = 3'd0;
          snap    = 1'b1;
        end
        BLANK, DRIVE: begin
          if (slot_q == SLOT_LAST) begin
            // Every slot opens with blanking, so a digit change is never lit.
            state_d = BLANK;
            slot_d  = '0;
            if (idx_q == 3'd5) begin
              idx_d = 3'd0;
              snap  = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            slot_d  = slot_q + SLOT_W'(1);
            state_d = (slot_d >= SLOT_DRIVE) ? DRIVE : BLANK;
          end
        end
        default: begin
          state_d = IDLE;
          slot_d  = '0;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  // Free-running blink timebase; the phase flips every BLINK_HALF clocks.
  always_comb begin
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
      blink_phase_d = blink_phase_q;
    end
  end

  // Output decode from the upcoming state so the outputs can be registered.
  always_comb begin
    seg_out_d    = SEG_OFF;
    dig_sel_d    = DIG_NONE;
    frame_tick_d = snap;
    one_hot      = 6'b000001 << idx_d;
    if (state_d == DRIVE) begin
      dig_sel_d = DIG_ACTIVE_LOW ? ~one_hot : one_hot;
      if (blink_en && blink_mask[idx_d] && blink_phase_d) begin
        seg_out_d = SEG_OFF;
      end else begin
        seg_out_d = shadow_q[idx_d];
      end
    end else begin
      seg_out_d = SEG_OFF;
      dig_sel_d = DIG_NONE;
    end
  end

  // Scan state, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      idx_q         <= 3'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_out_q     <= SEG_OFF;
      dig_sel_q     <= DIG_NONE;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_out_q     <= seg_out_d;
      dig_sel_q     <= dig_sel_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  // Frame shadow registers: captured together at the start of each frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= SEG_OFF;
      end
    end else if (snap) begin
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= in_pat[i];
      end
    end
  end

  assign seg_out    = seg_out_q;
  assign dig_sel    = dig_sel_q;
  assign frame_tick = frame_tick_q;

endmodule
